// File: rtl/proc_ctrl_fsm.sv
// proc_ctrl_fsm: instruction-sequencing controller for the distributed processor core.
// Fetches an instruction (fixed memory read latency), decodes opcode[7:4], then sequences
// pulse writes, fproc/sync handshakes and ALU latency while driving the datapath enables.
// Handshake waits can time out into a sticky ERROR state; DONE and ERROR leave only by reset.
module proc_ctrl_fsm #(
    parameter int MEM_READ_CYCLES = 3,
    parameter int ALU_LATENCY     = 1,
    parameter int WAIT_TIMEOUT    = 0,
    parameter int TMO_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] opcode,
    input  logic       fproc_ready,
    input  logic       sync_enable,
    input  logic       cstrobe_in,
    output logic [2:0] alu_opcode,
    output logic       alu_in0_sel,
    output logic [1:0] alu_in1_sel,
    output logic       reg_write_en,
    output logic       qclk_load_en,
    output logic       write_pulse_en,
    output logic       c_strobe_enable,
    output logic       instr_ptr_en,
    output logic [1:0] instr_ptr_load_en,
    output logic       instr_load_en,
    output logic       fproc_out_ready,
    output logic       sync_out_ready,
    output logic       done_stb,
    output logic       err,
    output logic [1:0] err_code
);

    typedef enum logic [3:0] {
        S_MEM_WAIT,
        S_DECODE,
        S_TRIG_WAIT,
        S_FPROC_WAIT,
        S_SYNC_WAIT,
        S_ALU_WAIT,
        S_ALU_COMMIT,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [3:0] OP_REG_ALU    = 4'b0001;
    localparam logic [3:0] OP_JUMP_I     = 4'b0010;
    localparam logic [3:0] OP_JUMP_COND  = 4'b0011;
    localparam logic [3:0] OP_ALU_FPROC  = 4'b0100;
    localparam logic [3:0] OP_JUMP_FPROC = 4'b0101;
    localparam logic [3:0] OP_INC_QCLK   = 4'b0110;
    localparam logic [3:0] OP_SYNC       = 4'b0111;
    localparam logic [3:0] OP_PULSE      = 4'b1000;
    localparam logic [3:0] OP_PULSE_TRIG = 4'b1001;
    localparam logic [3:0] OP_DONE       = 4'b1010;

    localparam logic [1:0] SEL_QCLK  = 2'b00;
    localparam logic [1:0] SEL_REG   = 2'b01;
    localparam logic [1:0] SEL_FPROC = 2'b10;

    localparam logic [1:0] EC_NONE  = 2'b00;
    localparam logic [1:0] EC_ILLOP = 2'b01;
    localparam logic [1:0] EC_FPROC = 2'b10;
    localparam logic [1:0] EC_SYNC  = 2'b11;

    // One shared phase counter serves MEM_WAIT and ALU_WAIT (never active together).
    localparam int CNT_MAX = (MEM_READ_CYCLES > ALU_LATENCY) ? MEM_READ_CYCLES : ALU_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALU_LAST = CNT_W'(ALU_LATENCY - 1);
    // The counter holds the number of wait cycles already completed, so the cycle in which
    // it equals WAIT_TIMEOUT-1 is the last one the condition may still arrive in.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo_cnt;
    logic [1:0]       err_code_q, err_code_nxt;
    logic [3:0]       op;
    logic [1:0]       op_sel;
    logic             tmo_hit;

    assign op          = opcode[7:4];
    assign alu_opcode  = opcode[2:0];
    assign alu_in0_sel = opcode[3];
    assign tmo_hit     = (WAIT_TIMEOUT > 0) && (tmo_cnt == TMO_LAST);

    // Second ALU operand implied by the instruction class; held from DECODE through COMMIT.
    always_comb begin
        case (op)
            OP_REG_ALU, OP_JUMP_COND:    op_sel = SEL_REG;
            OP_ALU_FPROC, OP_JUMP_FPROC: op_sel = SEL_FPROC;
            default:                     op_sel = SEL_QCLK;
        endcase
    end

    // State register; counters restart whenever the state changes, otherwise saturate.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_MEM_WAIT;
            cnt        <= '0;
            tmo_cnt    <= '0;
            err_code_q <= EC_NONE;
        end else begin
            state      <= state_nxt;
            err_code_q <= err_code_nxt;
            if (state_nxt != state) begin
                cnt     <= '0;
                tmo_cnt <= '0;
            end else begin
                if (cnt != '1)     cnt     <= cnt + 1'b1;
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end

    // Next-state and datapath enables; everything is forced low while reset is held.
    always_comb begin
        state_nxt         = state;
        err_code_nxt      = err_code_q;
        alu_in1_sel       = SEL_QCLK;
        reg_write_en      = 1'b0;
        qclk_load_en      = 1'b0;
        write_pulse_en    = 1'b0;
        c_strobe_enable   = 1'b0;
        instr_ptr_en      = 1'b0;
        instr_ptr_load_en = 2'b00;
        instr_load_en     = 1'b0;
        fproc_out_ready   = 1'b0;
        sync_out_ready    = 1'b0;
        done_stb          = 1'b0;
        err               = 1'b0;

        case (state)
            S_MEM_WAIT: begin
                if (cnt == MEM_LAST) begin
                    instr_load_en = 1'b1;
                    instr_ptr_en  = 1'b1;
                    state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_PULSE: begin
                        write_pulse_en = 1'b1;
                        state_nxt      = S_MEM_WAIT;
                    end
                    OP_PULSE_TRIG: begin
                        write_pulse_en  = 1'b1;
                        c_strobe_enable = 1'b1;
                        state_nxt       = cstrobe_in ? S_MEM_WAIT : S_TRIG_WAIT;
                    end
                    OP_REG_ALU, OP_JUMP_COND, OP_INC_QCLK: begin
                        alu_in1_sel = op_sel;
                        state_nxt   = S_ALU_WAIT;
                    end
                    OP_JUMP_I: begin
                        instr_ptr_load_en = 2'b01;
                        state_nxt         = S_MEM_WAIT;
                    end
                    OP_ALU_FPROC, OP_JUMP_FPROC: begin
                        alu_in1_sel     = op_sel;
                        fproc_out_ready = 1'b1;
                        state_nxt       = S_FPROC_WAIT;
                    end
                    OP_SYNC: begin
                        sync_out_ready = 1'b1;
                        state_nxt      = S_SYNC_WAIT;
                    end
                    OP_DONE: state_nxt = S_DONE;
                    default: begin
                        state_nxt    = S_ERROR;
                        err_code_nxt = EC_ILLOP;
                    end
                endcase
            end
            S_TRIG_WAIT: begin
                write_pulse_en  = 1'b1;
                c_strobe_enable = 1'b1;
                if (cstrobe_in) begin
                    state_nxt = S_MEM_WAIT;
                end else if (tmo_hit) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = EC_SYNC;
                end
            end
            S_FPROC_WAIT: begin
                alu_in1_sel = SEL_FPROC;
                if (fproc_ready) begin
                    state_nxt = S_ALU_WAIT;
                end else if (tmo_hit) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = EC_FPROC;
                end
            end
            S_SYNC_WAIT: begin
                if (sync_enable) begin
                    state_nxt = S_MEM_WAIT;
                end else if (tmo_hit) begin
                    state_nxt    = S_ERROR;
                    err_code_nxt = EC_SYNC;
                end
            end
            S_ALU_WAIT: begin
                alu_in1_sel = op_sel;
                if (cnt == ALU_LAST) state_nxt = S_ALU_COMMIT;
            end
            S_ALU_COMMIT: begin
                alu_in1_sel = op_sel;
                case (op)
                    OP_REG_ALU, OP_ALU_FPROC:   reg_write_en      = 1'b1;
                    OP_INC_QCLK:                qclk_load_en      = 1'b1;
                    OP_JUMP_COND, OP_JUMP_FPROC: instr_ptr_load_en = 2'b10;
                    default: ;
                endcase
                state_nxt = S_MEM_WAIT;
            end
            S_DONE:  done_stb = 1'b1;
            S_ERROR: err      = 1'b1;
            default: state_nxt = S_MEM_WAIT;
        endcase

        if (!reset) begin
            alu_in1_sel       = SEL_QCLK;
            reg_write_en      = 1'b0;
            qclk_load_en      = 1'b0;
            write_pulse_en    = 1'b0;
            c_strobe_enable   = 1'b0;
            instr_ptr_en      = 1'b0;
            instr_ptr_load_en = 2'b00;
            instr_load_en     = 1'b0;
            fproc_out_ready   = 1'b0;
            sync_out_ready    = 1'b0;
            done_stb          = 1'b0;
            err               = 1'b0;
        end
    end

    assign err_code = reset ? err_code_q : EC_NONE;

endmodule

// File: tb/tb_proc_ctrl_fsm.sv
// tb_proc_ctrl_fsm: two controllers (one with a 4-cycle wait timeout, one that never times
// out) run the same instruction stream. Each instruction is expanded into its expected
// per-cycle output trace from its phases (fetch, decode, wait, ALU latency, commit).
module tb_proc_ctrl_fsm;

    localparam int M = 3;  // memory read cycles
    localparam int L = 2;  // ALU latency
    localparam int T = 4;  // wait timeout of instance a

    typedef struct packed {
        logic       ld, ipe, wp, cse, rwe, qle;
        logic [1:0] ipl;
        logic       fo, so, dn, er;
        logic [1:0] ec;
    } outs_t;

    logic clk = 1'b0;
    logic reset, fproc_ready, sync_enable, cstrobe_in;
    logic [7:0] opcode;

    logic [2:0] a_alu_opcode, b_alu_opcode;
    logic       a_alu_in0_sel, b_alu_in0_sel;
    logic [1:0] a_alu_in1_sel, b_alu_in1_sel;
    logic       a_reg_write_en, a_qclk_load_en, a_write_pulse_en, a_c_strobe_enable;
    logic       b_reg_write_en, b_qclk_load_en, b_write_pulse_en, b_c_strobe_enable;
    logic       a_instr_ptr_en, a_instr_load_en, a_fproc_out_ready, a_sync_out_ready;
    logic       b_instr_ptr_en, b_instr_load_en, b_fproc_out_ready, b_sync_out_ready;
    logic [1:0] a_instr_ptr_load_en, b_instr_ptr_load_en, a_err_code, b_err_code;
    logic       a_done_stb, b_done_stb, a_err, b_err;
    outs_t      obs_a, obs_b;

    int    n_tests = 0;
    int    n_fail  = 0;
    bit    a_dead  = 1'b0;
    outs_t a_err_v = '0;

    always #5 clk = ~clk;

    proc_ctrl_fsm #(.MEM_READ_CYCLES(M), .ALU_LATENCY(L), .WAIT_TIMEOUT(T), .TMO_W(3)) u_a (
        .clk(clk), .reset(reset), .opcode(opcode), .fproc_ready(fproc_ready),
        .sync_enable(sync_enable), .cstrobe_in(cstrobe_in),
        .alu_opcode(a_alu_opcode), .alu_in0_sel(a_alu_in0_sel), .alu_in1_sel(a_alu_in1_sel),
        .reg_write_en(a_reg_write_en), .qclk_load_en(a_qclk_load_en),
        .write_pulse_en(a_write_pulse_en), .c_strobe_enable(a_c_strobe_enable),
        .instr_ptr_en(a_instr_ptr_en), .instr_ptr_load_en(a_instr_ptr_load_en),
        .instr_load_en(a_instr_load_en), .fproc_out_ready(a_fproc_out_ready),
        .sync_out_ready(a_sync_out_ready), .done_stb(a_done_stb), .err(a_err),
        .err_code(a_err_code)
    );

    proc_ctrl_fsm #(.MEM_READ_CYCLES(M), .ALU_LATENCY(L), .WAIT_TIMEOUT(0), .TMO_W(2)) u_b (
        .clk(clk), .reset(reset), .opcode(opcode), .fproc_ready(fproc_ready),
        .sync_enable(sync_enable), .cstrobe_in(cstrobe_in),
        .alu_opcode(b_alu_opcode), .alu_in0_sel(b_alu_in0_sel), .alu_in1_sel(b_alu_in1_sel),
        .reg_write_en(b_reg_write_en), .qclk_load_en(b_qclk_load_en),
        .write_pulse_en(b_write_pulse_en), .c_strobe_enable(b_c_strobe_enable),
        .instr_ptr_en(b_instr_ptr_en), .instr_ptr_load_en(b_instr_ptr_load_en),
        .instr_load_en(b_instr_load_en), .fproc_out_ready(b_fproc_out_ready),
        .sync_out_ready(b_sync_out_ready), .done_stb(b_done_stb), .err(b_err),
        .err_code(b_err_code)
    );

    assign obs_a = {a_instr_load_en, a_instr_ptr_en, a_write_pulse_en, a_c_strobe_enable,
                    a_reg_write_en, a_qclk_load_en, a_instr_ptr_load_en, a_fproc_out_ready,
                    a_sync_out_ready, a_done_stb, a_err, a_err_code};
    assign obs_b = {b_instr_load_en, b_instr_ptr_en, b_write_pulse_en, b_c_strobe_enable,
                    b_reg_write_en, b_qclk_load_en, b_instr_ptr_load_en, b_fproc_out_ready,
                    b_sync_out_ready, b_done_stb, b_err, b_err_code};

    task automatic chk(input string tag, input string who, input logic [13:0] got,
                       input logic [13:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%h expected=%h", tag, who, got, exp);
        end
    endtask

    // One clock: drive inputs (noise except the named handshake), sample at negedge.
    // cid: 0 none, 1 fproc_ready, 2 sync_enable, 3 cstrobe_in.
    task automatic cyc(input string tag, input outs_t e, input bit selchk,
                       input logic [1:0] sel, input int cid, input bit cv);
        fproc_ready = 1'($urandom);
        sync_enable = 1'($urandom);
        cstrobe_in  = 1'($urandom);
        case (cid)
            1: fproc_ready = cv;
            2: sync_enable = cv;
            3: cstrobe_in  = cv;
            default: ;
        endcase
        @(negedge clk);
        chk(tag, "a", obs_a, a_dead ? a_err_v : e);
        chk(tag, "b", obs_b, e);
        chk({tag, "_alu"}, "b", 14'({b_alu_in0_sel, b_alu_opcode}), 14'(opcode[3:0]));
        if (!a_dead)
            chk({tag, "_alu"}, "a", 14'({a_alu_in0_sel, a_alu_opcode}), 14'(opcode[3:0]));
        if (selchk) begin
            chk({tag, "_sel"}, "b", 14'(b_alu_in1_sel), 14'(sel));
            if (!a_dead) chk({tag, "_sel"}, "a", 14'(a_alu_in1_sel), 14'(sel));
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset at posedge+1 (mid-cycle abort), check outputs, release a cycle later.
    task automatic do_reset();
        reset       = 1'b0;
        a_dead      = 1'b0;
        fproc_ready = 1'($urandom);
        sync_enable = 1'($urandom);
        cstrobe_in  = 1'($urandom);
        @(negedge clk);
        chk("reset", "a", obs_a, '0);
        chk("reset", "b", obs_b, '0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic kill_a(input int k, input logic [1:0] code);
        if (k > T && !a_dead) begin
            a_dead     = 1'b1;
            a_err_v    = '0;
            a_err_v.er = 1'b1;
            a_err_v.ec = code;
        end
    endtask

    task automatic alu_phase(input logic [3:0] c, input logic [1:0] sel);
        outs_t e;
        for (int i = 0; i < L; i++) cyc("alu_wait", '0, 1'b1, sel, 0, 1'b0);
        e = '0;
        if (c == 4'h1 || c == 4'h4) e.rwe = 1'b1;
        if (c == 4'h6) e.qle = 1'b1;
        if (c == 4'h3 || c == 4'h5) e.ipl = 2'b10;
        cyc("commit", e, 1'b0, 2'b00, 0, 1'b0);
    endtask

    // d: wait cycle in which the handshake arrives (trig: 0 = during decode).
    // abort_k: wait cycle in which reset is pulsed instead (0 = never).
    task automatic instr(input logic [7:0] op, input int d, input int abort_k);
        outs_t      e;
        logic [3:0] c;
        c      = op[7:4];
        opcode = op;
        for (int i = 1; i <= M; i++) begin
            e = '0;
            if (i == M) begin e.ld = 1'b1; e.ipe = 1'b1; end
            cyc("fetch", e, 1'b0, 2'b00, 0, 1'b0);
        end
        e = '0;
        case (c)
            4'h8: begin e.wp = 1'b1; cyc("pulse", e, 1'b0, 2'b00, 0, 1'b0); end
            4'h9: begin
                e.wp = 1'b1; e.cse = 1'b1;
                cyc("trig_dec", e, 1'b0, 2'b00, 3, d == 0);
                for (int k = 1; k <= d; k++) begin
                    if (k == abort_k) begin do_reset(); return; end
                    kill_a(k, 2'b11);
                    cyc("trig_wait", e, 1'b0, 2'b00, 3, k == d);
                end
            end
            4'h2: begin e.ipl = 2'b01; cyc("jump_i", e, 1'b0, 2'b00, 0, 1'b0); end
            4'h1, 4'h3, 4'h6: begin
                cyc("alu_dec", e, 1'b1, (c == 4'h6) ? 2'b00 : 2'b01, 0, 1'b0);
                alu_phase(c, (c == 4'h6) ? 2'b00 : 2'b01);
            end
            4'h4, 4'h5: begin
                e.fo = 1'b1;
                cyc("fproc_dec", e, 1'b0, 2'b00, 0, 1'b0);
                for (int k = 1; k <= d; k++) begin
                    kill_a(k, 2'b10);
                    cyc("fproc_wait", '0, 1'b1, 2'b10, 1, k == d);
                end
                alu_phase(c, 2'b10);
            end
            4'h7: begin
                e.so = 1'b1;
                cyc("sync_dec", e, 1'b0, 2'b00, 0, 1'b0);
                for (int k = 1; k <= d; k++) begin
                    kill_a(k, 2'b11);
                    cyc("sync_wait", '0, 1'b0, 2'b00, 2, k == d);
                end
            end
            4'hA: begin
                cyc("done_dec", e, 1'b0, 2'b00, 0, 1'b0);
                e.dn = 1'b1;
                for (int i = 0; i < 3; i++) cyc("done", e, 1'b0, 2'b00, 0, 1'b0);
                do_reset();
            end
            default: begin
                cyc("ill_dec", e, 1'b0, 2'b00, 0, 1'b0);
                e.er = 1'b1; e.ec = 2'b01;
                for (int i = 0; i < 3; i++) cyc("illegal", e, 1'b0, 2'b00, 0, 1'b0);
                do_reset();
            end
        endcase
        if (a_dead) do_reset();
    endtask

    initial begin
        logic [3:0] legal [9];
        legal = '{4'h8, 4'h9, 4'h1, 4'h3, 4'h6, 4'h2, 4'h4, 4'h5, 4'h7};
        opcode = 8'h00;
        reset  = 1'b0;
        fproc_ready = 1'b0; sync_enable = 1'b0; cstrobe_in = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        instr(8'h85, 0, 0);      // pulse; fetch load at cycle 3, pulse at 4, load at 7
        instr(8'h8A, 0, 0);
        instr(8'h1B, 0, 0);      // reg ALU, 2 latency cycles then reg write
        instr(8'h63, 0, 0);      // inc qclk
        instr(8'h3E, 0, 0);      // jump cond
        instr(8'h27, 0, 0);      // jump immediate
        instr(8'h4D, 2, 0);      // ALU fproc
        instr(8'h5C, 5, 0);      // jump fproc, ready after 5: only instance a times out
        instr(8'h71, 4, 0);      // sync on the expiry cycle wins
        instr(8'h72, 9, 0);      // sync late: a errors with code 11
        instr(8'h94, 0, 0);      // trig strobe during decode
        instr(8'h95, 4, 0);      // trig on the expiry cycle
        instr(8'h96, 6, 0);      // trig late: a errors
        instr(8'hF0, 0, 0);      // illegal op, sticky error
        instr(8'hA0, 0, 0);      // done held
        instr(8'h93, 7, 3);      // reset mid trig wait
        instr(8'h81, 0, 0);      // clean restart

        for (int n = 0; n < 60; n++) begin
            logic [3:0] c;
            int         d;
            if ($urandom_range(0, 11) == 0)
                c = ($urandom_range(0, 1) == 0) ? 4'hA : 4'(4'hB + $urandom_range(0, 4));
            else
                c = legal[$urandom_range(0, 8)];
            d = (c == 4'h9) ? int'($urandom_range(0, 6)) : int'($urandom_range(1, 7));
            instr({c, 4'($urandom)}, d, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
